// File: rtl/spectrum_smoother.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_smoother
//  Purpose  : Per-bin spectrum smoothing (bypass / EMA / peak-hold-decay) with
//             a one-entry write forwarding path and a state-RAM clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
module spectrum_smoother #(
   parameter int ADDR_BITS   = 8,
   parameter int DATA_BITS   = 9,
   parameter int ALPHA_SHIFT = 2,
   parameter int DECAY_STEP  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic                 clear,
   input  logic [ADDR_BITS-1:0] in_addr,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic [ADDR_BITS-1:0] out_addr,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int                   c_depth     = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] c_last_addr = {ADDR_BITS{1'b1}};
   localparam logic [DATA_BITS-1:0] c_decay     = DATA_BITS'(DECAY_STEP);
   localparam logic [1:0]           c_mode_ema  = 2'b01;
   localparam logic [1:0]           c_mode_peak = 2'b10;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [ADDR_BITS-1:0]   r_sweep_addr;

   logic [DATA_BITS-1:0]   r_ram [0:c_depth-1];
   logic [DATA_BITS-1:0]   r_rd_data;

   logic                   r_s1_valid;
   logic [ADDR_BITS-1:0]   r_s1_addr;
   logic [DATA_BITS-1:0]   r_s1_data;
   logic [1:0]             r_s1_mode;
   logic                   r_fwd_hit;
   logic [DATA_BITS-1:0]   r_fwd_data;

   logic                   w_accept;
   logic [DATA_BITS-1:0]   w_old;
   logic signed [DATA_BITS:0] w_diff;
   logic signed [DATA_BITS:0] w_step;
   logic signed [DATA_BITS:0] w_ema_sum;
   logic [DATA_BITS-1:0]   w_ema;
   logic [DATA_BITS-1:0]   w_peak;
   logic [DATA_BITS-1:0]   w_new;
   logic                   w_wr_en;
   logic [ADDR_BITS-1:0]   w_wr_addr;
   logic [DATA_BITS-1:0]   w_wr_data;

   // ---------------- clear sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SWEEP;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (clear) w_state_next = SWEEP;
         SWEEP:   if (r_sweep_addr == c_last_addr) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sweep_addr <= '0;
      end else if (r_state == SWEEP) begin
         r_sweep_addr <= r_sweep_addr + 1'b1;
      end else begin
         r_sweep_addr <= '0;
      end
   end

   assign busy     = (r_state == SWEEP);
   assign w_accept = in_valid && (r_state == IDLE) && !clear;

   // Sweep owns the single write port; a colliding pipeline write is dropped.
   assign w_wr_en   = (r_state == SWEEP) || r_s1_valid;
   assign w_wr_addr = (r_state == SWEEP) ? r_sweep_addr : r_s1_addr;
   assign w_wr_data = (r_state == SWEEP) ? '0 : w_new;

   // ---------------- state RAM (read-before-write) ----------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_ram[w_wr_addr] <= w_wr_data;
      end
      r_rd_data <= r_ram[in_addr];
   end

   // ---------------- stage 1: update compute ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_data  <= '0;
         r_s1_mode  <= '0;
         r_fwd_hit  <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_s1_valid <= w_accept;
         r_s1_addr  <= in_addr;
         r_s1_data  <= in_data;
         r_s1_mode  <= mode;
         // The RAM read issued this cycle misses the write landing on the same edge.
         r_fwd_hit  <= w_wr_en && (w_wr_addr == in_addr);
         r_fwd_data <= w_wr_data;
      end
   end

   assign w_old     = r_fwd_hit ? r_fwd_data : r_rd_data;
   assign w_diff    = $signed({1'b0, r_s1_data}) - $signed({1'b0, w_old});
   assign w_step    = w_diff >>> ALPHA_SHIFT;
   assign w_ema_sum = $signed({1'b0, w_old}) + w_step;
   assign w_ema     = w_ema_sum[DATA_BITS-1:0];

   always_comb begin
      w_peak = '0;
      if (r_s1_data >= w_old) begin
         w_peak = r_s1_data;
      end else if (w_old > c_decay) begin
         w_peak = w_old - c_decay;
      end
   end

   always_comb begin
      w_new = r_s1_data;
      case (r_s1_mode)
         c_mode_ema:  w_new = w_ema;
         c_mode_peak: w_new = w_peak;
         default:     w_new = r_s1_data;
      endcase
   end

   // ---------------- stage 2: output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= r_s1_valid;
         frame_done <= r_s1_valid && (r_s1_addr == c_last_addr);
         if (r_s1_valid) begin
            out_addr <= r_s1_addr;
            out_data <= w_new;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spectrum_smoother.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spectrum_smoother
//  Purpose  : Scoreboard bench for spectrum_smoother with a per-bin model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spectrum_smoother;

   typedef struct {
      logic [7:0] addr;
      logic [8:0] data;
      logic       fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       clear;
   logic [7:0] in_addr;
   logic [8:0] in_data;
   logic       in_valid;
   logic [7:0] out_addr;
   logic [8:0] out_data;
   logic       out_valid;
   logic       frame_done;
   logic       busy;

   int   n_checks = 0;
   int   n_errors = 0;
   int   mdl [256];
   exp_t exp_q [$];
   int   obs_q [$];
   int   last_data = 0;
   int   fd_count = 0;

   always #5 clk = ~clk;

   spectrum_smoother #(
      .ADDR_BITS   (8),
      .DATA_BITS   (9),
      .ALPHA_SHIFT (2),
      .DECAY_STEP  (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .clear      (clear),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .busy       (busy)
   );

   task automatic model_zero();
      for (int i = 0; i < 256; i++) mdl[i] = 0;
   endtask

   // Drives one sample for a full cycle and pushes the model's prediction.
   task automatic drive(input int a, input int d, input logic [1:0] m);
      int   old;
      int   nv;
      int   diff;
      exp_t e;
      @(negedge clk);
      in_addr  = a[7:0];
      in_data  = d[8:0];
      mode     = m;
      in_valid = 1'b1;
      old = mdl[a];
      case (m)
         2'b01: begin
            diff = d - old;
            nv   = old + ((diff >= 0) ? (diff / 4) : -((-diff + 3) / 4));
         end
         2'b10:   nv = (d >= old) ? d : ((old > 0) ? old - 1 : 0);
         default: nv = d;
      endcase
      mdl[a] = nv;
      e.addr = a[7:0];
      e.data = nv[8:0];
      e.fd   = (a == 255);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int t;
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Counts busy cycles; optionally drives junk samples and a repeated clear.
   task automatic wait_sweep(input bit junk, output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         cnt++;
         if (junk) begin
            in_valid = 1'b1;
            in_addr  = 8'($urandom_range(0, 255));
            in_data  = 9'($urandom_range(0, 511));
            mode     = 2'b01;
            clear    = (cnt == 10);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            obs_q.push_back(int'(out_data));
            last_data = int'(out_data);
            if (frame_done === 1'b1) fd_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_output: addr=%0d data=%0d, required no output", out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_addr !== e.addr) begin
                  n_errors++;
                  $display("FAIL out_addr: got %0d, required %0d", out_addr, e.addr);
               end
               n_checks++;
               if (out_data !== e.data) begin
                  n_errors++;
                  $display("FAIL out_data bin %0d: got %0d, required %0d", e.addr, out_data, e.data);
               end
               n_checks++;
               if (frame_done !== e.fd) begin
                  n_errors++;
                  $display("FAIL frame_done bin %0d: got %0b, required %0b", e.addr, frame_done, e.fd);
               end
            end
         end else if (rst_n === 1'b1 && frame_done !== 1'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_done_alone: got %0b without out_valid, required 0", frame_done);
         end
      end
   endtask

   task automatic test_reset();
      int cnt;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      mode     = 2'b00;
      in_addr  = '0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      n_checks++;
      if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
      n_checks++;
      if (out_addr !== 8'd0) begin n_errors++; $display("FAIL reset_out_addr: got %0d, required 0", out_addr); end
      n_checks++;
      if (out_data !== 9'd0) begin n_errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
      rst_n = 1'b1;
      model_zero();
      wait_sweep(1'b0, cnt);
      n_checks++;
      if (cnt != 256) begin n_errors++; $display("FAIL reset_sweep_len: got %0d busy cycles, required 256", cnt); end
      obs_q.delete();
      drive(5, 100, 2'b01);
      drain();
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] != 25) begin
         n_errors++;
         $display("FAIL first_ema: got %0d outputs (first %0d), required one output of 25", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
      end
   endtask

   task automatic test_hazard();
      int req [4] = '{64, 112, 148, 175};
      obs_q.delete();
      for (int i = 0; i < 4; i++) drive(7, 256, 2'b01);
      drain();
      n_checks++;
      if (obs_q.size() != 4) begin
         n_errors++;
         $display("FAIL hazard_count: got %0d outputs, required 4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_q[i] != req[i]) begin
               n_errors++;
               $display("FAIL hazard_seq[%0d]: got %0d, required %0d", i, obs_q[i], req[i]);
            end
         end
      end
   endtask

   task automatic test_mode_switch();
      int req [4] = '{50, 49, 77, 58};
      obs_q.delete();
      drive(40, 200, 2'b01);
      drive(40, 10,  2'b10);
      drive(40, 77,  2'b00);
      drive(40, 1,   2'b01);
      drain();
      n_checks++;
      if (obs_q.size() != 4) begin
         n_errors++;
         $display("FAIL mode_switch_count: got %0d outputs, required 4", obs_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_q[i] != req[i]) begin
               n_errors++;
               $display("FAIL mode_switch[%0d]: got %0d, required %0d", i, obs_q[i], req[i]);
            end
         end
      end
   endtask

   task automatic test_ema_convergence();
      int prev = 0;
      for (int f = 0; f < 40; f++) begin
         drive(3, 400, 2'b01);
         drain();
         n_checks++;
         if (last_data < prev || last_data > 400) begin
            n_errors++;
            $display("FAIL ema_monotonic frame %0d: got %0d after %0d, required %0d..400", f, last_data, prev, prev);
         end
         prev = last_data;
      end
      n_checks++;
      if (last_data < 397 || last_data > 400) begin
         n_errors++;
         $display("FAIL ema_final: got %0d, required 397..400", last_data);
      end
   endtask

   task automatic test_peak_decay();
      int req [3] = '{300, 299, 298};
      obs_q.delete();
      drive(10, 300, 2'b10);
      for (int i = 0; i < 310; i++) drive(10, 0, 2'b10);
      drain();
      n_checks++;
      if (obs_q.size() != 311) begin
         n_errors++;
         $display("FAIL peak_count: got %0d outputs, required 311", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_q[i] != req[i]) begin
               n_errors++;
               $display("FAIL peak_seq[%0d]: got %0d, required %0d", i, obs_q[i], req[i]);
            end
         end
      end
      n_checks++;
      if (last_data != 0) begin
         n_errors++;
         $display("FAIL peak_floor: got %0d, required 0", last_data);
      end
   endtask

   task automatic test_frame();
      int d;
      fd_count = 0;
      for (int a = 0; a < 256; a++) begin
         d = $urandom_range(0, 511);
         drive(a, d, (a % 2 == 0) ? 2'b00 : 2'b11);
      end
      drain();
      n_checks++;
      if (fd_count != 1) begin
         n_errors++;
         $display("FAIL frame_done_count: got %0d pulses, required 1", fd_count);
      end
   endtask

   task automatic test_clear_collision();
      int cnt;
      drive(20, 200, 2'b01);
      drive(21, 300, 2'b10);
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_addr  = 8'd22;
      in_data  = 9'd50;
      mode     = 2'b00;
      model_zero();
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      wait_sweep(1'b1, cnt);
      n_checks++;
      if (cnt != 256) begin n_errors++; $display("FAIL clear_sweep_len: got %0d busy cycles, required 256", cnt); end
      drain();
      obs_q.delete();
      drive(20, 100, 2'b01);
      drive(21, 100, 2'b01);
      drain();
      n_checks++;
      if (obs_q.size() != 2 || obs_q[0] != 25 || obs_q[1] != 25) begin
         n_errors++;
         $display("FAIL post_clear_ema: got %0d outputs (first %0d), required two outputs of 25", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
      end
   endtask

   task automatic test_reset_abort();
      int cnt;
      drive(100, 10, 2'b00);
      drive(101, 20, 2'b00);
      drive(250, 400, 2'b00);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      model_zero();
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 9'd0) begin
         n_errors++;
         $display("FAIL abort_outputs: got valid=%0b data=%0d, required 0/0", out_valid, out_data);
      end
      rst_n = 1'b1;
      wait_sweep(1'b0, cnt);
      n_checks++;
      if (cnt != 256) begin n_errors++; $display("FAIL abort_sweep_len: got %0d busy cycles, required 256", cnt); end
      obs_q.delete();
      drive(250, 100, 2'b01);
      drain();
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] != 25) begin
         n_errors++;
         $display("FAIL abort_ema: got %0d outputs (first %0d), required one output of 25", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_hazard();
      test_mode_switch();
      test_ema_convergence();
      test_peak_decay();
      test_frame();
      test_clear_collision();
      test_reset_abort();
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
